// File: rtl/srfpu_pkg.sv
// Shared SRFPU definitions: sequencer states, op encoding and quotient sizing.
package srfpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Quotient width: hidden bit, mantissa, round bits, plus one integer guard bit.
  function automatic int qw_f(input int mant_width, input int num_round_bits);
    return mant_width + num_round_bits + 2;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Operand/result handshake bundle between unpack/LZD and the normaliser.
interface muldiv_seq_if #(
  parameter int exp_width  = 8,
  parameter int mant_width = 23
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          op_div;
  logic        [mant_width-1:0]  mantA;
  logic        [mant_width-1:0]  mantB;
  logic signed [exp_width+1:0]   expA;
  logic signed [exp_width+1:0]   expB;
  logic signed [exp_width+1:0]   lz;
  logic                          out_valid;
  logic                          out_ready;
  logic        [2*mant_width+1:0] unnorm_mant;
  logic signed [exp_width+1:0]   unnorm_exp;
  logic                          sticky;

  modport master (
    output in_valid, op_div, mantA, mantB, expA, expB, lz, out_ready,
    input  in_ready, out_valid, unnorm_mant, unnorm_exp, sticky
  );

  modport slave (
    input  in_valid, op_div, mantA, mantB, expA, expB, lz, out_ready,
    output in_ready, out_valid, unnorm_mant, unnorm_exp, sticky
  );
endinterface

// File: rtl/restoring_div_step.sv
// One radix-2 restoring division iteration on the partial remainder.
module restoring_div_step #(
  parameter int mant_width = 23
) (
  input  logic [mant_width+1:0] rem,
  input  logic [mant_width:0]   mb,
  output logic [mant_width+1:0] rem_next,
  output logic                  qbit
);
  logic signed [mant_width+2:0] trial;

  // rem < 2*mb always holds, so a successful trial shifted left still fits.
  always_comb begin
    trial    = $signed({1'b0, rem}) - $signed({2'b00, mb});
    qbit     = ~trial[mant_width+2];
    rem_next = qbit ? (trial[mant_width+1:0] << 1) : (rem << 1);
  end
endmodule

// File: rtl/muldiv_seq.sv
// Sequential mantissa multiply (one cycle) / restoring divide (QW cycles) with handshakes.
module muldiv_seq
  import srfpu_pkg::*;
#(
  parameter int exp_width      = 8,
  parameter int mant_width     = 23,
  parameter int num_round_bits = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  muldiv_seq_if.slave   bus
);
  localparam int EW = exp_width + 2;
  localparam int MW = 2*mant_width + 2;
  localparam int QW = qw_f(mant_width, num_round_bits);
  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(QW);

  muldiv_state_t state, state_nx;

  logic        [CW-1:0]         cnt;
  logic        [mant_width-1:0] shifted;
  logic                         accept;
  logic        [mant_width:0]   ma_p0, mb_p0;
  logic        [mant_width+1:0] rem_p1, rem_next;
  logic        [QW-2:0]         quo_p1;
  logic                         qbit;

  function automatic logic signed [EW-1:0] exp_result(
    input logic div, input logic signed [EW-1:0] a, input logic signed [EW-1:0] b);
    return div ? (a - b) : (a + b);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_nx = (bus.op_div == OP_DIV) ? DIV : MUL;
        MUL:  state_nx = DONE;
        DIV:  if (cnt == CW'(1)) state_nx = DONE;
        DONE: if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  always_comb begin
    accept  = (state == IDLE) && bus.in_valid && !flush;
    shifted = bus.mantA << bus.lz;
  end

  restoring_div_step #(.mant_width(mant_width)) u_step (
    .rem      (rem_p1),
    .mb       (mb_p0),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Stage p0: operands captured at acceptance; p1: divide iteration state.
  always_ff @(posedge clk) begin
    if (accept) begin
      ma_p0  <= {1'b1, shifted};
      mb_p0  <= {1'b1, bus.mantB};
      rem_p1 <= {1'b0, 1'b1, shifted};
      quo_p1 <= '0;
    end else if (state == DIV) begin
      rem_p1 <= rem_next;
      quo_p1 <= {quo_p1[QW-3:0], qbit};
    end
  end

  // Result stage: counter and the visible output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      bus.unnorm_mant <= '0;
      bus.unnorm_exp  <= '0;
      bus.sticky      <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt            <= (bus.op_div == OP_DIV) ? CNT_INIT : '0;
      bus.unnorm_exp <= exp_result(bus.op_div, bus.expA, bus.expB);
    end else if (state == MUL) begin
      bus.unnorm_mant <= MW'(ma_p0) * MW'(mb_p0);
      bus.sticky      <= 1'b0;
    end else if (state == DIV) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        bus.unnorm_mant <= MW'({quo_p1, qbit});
        bus.sticky      <= |rem_next;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomised and directed bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int EW   = 5;
  localparam int MANT = 4;
  localparam int NRB  = 2;
  localparam int QW   = MANT + NRB + 2;
  localparam int PW   = 2*MANT + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  muldiv_seq_if #(.exp_width(EW), .mant_width(MANT)) bus ();

  muldiv_seq #(.exp_width(EW), .mant_width(MANT), .num_round_bits(NRB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic        [PW-1:0]  m_mant;
  logic signed [EW+1:0]  m_exp;
  logic                  m_sticky;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference: plain integer product / long-division quotient of the hidden-bit mantissas.
  task automatic model(input logic div, input int a, input int b, input int ea, input int eb, input int lz);
    int ma, mb, e;
    ma = (1 << MANT) + ((a << lz) & ((1 << MANT) - 1));
    mb = (1 << MANT) + b;
    if (div) begin
      m_mant   = PW'((ma * (1 << (QW-1))) / mb);
      m_sticky = ((ma * (1 << (QW-1))) % mb) != 0;
      e        = ea - eb;
    end else begin
      m_mant   = PW'(ma * mb);
      m_sticky = 1'b0;
      e        = ea + eb;
    end
    m_exp = e[EW+1:0];
  endtask

  task automatic drive(input logic div, input int a, input int b, input int ea, input int eb, input int lz);
    bus.op_div = div;
    bus.mantA  = a[MANT-1:0];
    bus.mantB  = b[MANT-1:0];
    bus.expA   = ea[EW+1:0];
    bus.expB   = eb[EW+1:0];
    bus.lz     = lz[EW+1:0];
  endtask

  task automatic run_op(input string tag, input logic div, input int a, input int b,
                        input int ea, input int eb, input int lz, input int hold);
    int lat;
    model(div, a, b, ea, eb, lz);
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    drive(div, a, b, ea, eb, lz);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, div ? QW + 1 : 2);
    check({tag, "_out_valid"}, bus.out_valid, 1);
    check({tag, "_mant"}, bus.unnorm_mant, m_mant);
    check({tag, "_exp"}, bus.unnorm_exp, m_exp);
    check({tag, "_sticky"}, bus.sticky, m_sticky);
    check({tag, "_busy"}, bus.in_ready, 0);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
      check({tag, "_hold_mant"}, bus.unnorm_mant, m_mant);
      check({tag, "_hold_exp"}, bus.unnorm_exp, m_exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_release_ready"}, bus.in_ready, 1);
    check({tag, "_release_valid"}, bus.out_valid, 0);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mant", bus.unnorm_mant, 0);
    check("rst_exp", bus.unnorm_exp, 0);
    check("rst_sticky", bus.sticky, 0);
    rst_n = 1'b1;

    run_op("mul_ident", 1'b0, 0, 0, 3, 4, 0, 0);
    run_op("mul_lz", 1'b0, 3, 0, 1, 1, 2, 0);
    run_op("div_exact", 1'b1, 0, 0, 5, 2, 0, 0);
    run_op("div_inexact", 1'b1, 0, 8, -3, 4, 0, 5);
    run_op("b2b_mul", 1'b0, 15, 15, -10, -12, 0, 0);

    // Flush partway through a divide.
    @(negedge clk);
    drive(1'b1, 5, 9, 1, 1, 0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", bus.in_ready, 1);
    check("flush_valid", bus.out_valid, 0);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("flush_never_valid", seen, 0);

    // Flush together with in_valid in IDLE: nothing accepted.
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_vs_accept", bus.in_ready, 1);

    run_op("after_flush", 1'b1, 5, 9, 1, 1, 0, 1);

    // Asynchronous reset partway through a divide.
    @(negedge clk);
    drive(1'b1, 7, 3, 6, -2, 1);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_mant", bus.unnorm_mant, 0);
    check("arst_exp", bus.unnorm_exp, 0);
    check("arst_sticky", bus.sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_rst", 1'b1, 7, 3, 6, -2, 1, 0);

    for (int i = 0; i < 25; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20,
             int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
